// File: rtl/fetch_if.sv
// Purpose: fetch stage control/memory/decode-side bundle.
//   master (fetch) : in  enable, stall, redirect, redirect_pc, imem_rdata
//                    out imem_en, imem_addr, valid, pc_out, command, halted
//   slave  (env)   : mirror image of master
interface fetch_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              enable;
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              valid;
  logic [31:0]       pc_out;
  logic [31:0]       command;
  logic              halted;

  modport master (
    input  enable, stall, redirect, redirect_pc, imem_rdata,
    output imem_en, imem_addr, valid, pc_out, command, halted
  );

  modport slave (
    output enable, stall, redirect, redirect_pc, imem_rdata,
    input  imem_en, imem_addr, valid, pc_out, command, halted
  );
endinterface

// File: rtl/fetch.sv
// Purpose: instruction fetch stage. Owns the PC, reads a 1-cycle-latency BRAM and
//   presents {pc_out, command, valid} to decode through a 2-entry queue that absorbs
//   stall and redirect at 1 instr/cycle.
// Ports:
//   clk, rstn (async active-low)
//   bus (fetch_if.master): enable/stall/redirect/redirect_pc control, imem_en/imem_addr/
//     imem_rdata BRAM port, valid/pc_out/command/halted towards decode.
//   imem_en is a combinational strobe (same-cycle reaction to redirect/stall);
//   everything else is registered.
// Configuration: define FETCH_HALT_EN to stop issuing after an instruction with
//   opcode [31:26]==6'h3f is fetched; otherwise halted is tied 0.
module fetch #(
  parameter int unsigned ADDR_W   = 15,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic   clk,
  input  logic   rstn,
  fetch_if.master bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  entry_t      q0_q, q0_d;
  entry_t      q1_q, q1_d;
  logic [1:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic        halted_q;
`ifdef FETCH_HALT_EN
  logic        halted_d;
`endif

  logic        pop;
  logic        push;
  logic        issue;
  logic [1:0]  occ;
  entry_t      new_entry;

`ifndef FETCH_HALT_EN
  assign halted_q = 1'b0;
`endif

  // Next-state logic: queue shift/push, PC advance, redirect flush
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    q0_d          = q0_q;
    q1_d          = q1_q;
    count_d       = count_q;
    valid_d       = valid_q;
`ifdef FETCH_HALT_EN
    halted_d      = halted_q;
`endif

    occ  = count_q + 2'(inflight_q);
    pop  = valid_q & ~bus.stall & ~bus.redirect;
    // a response arriving after halt belongs to an instruction past the halt
    push = inflight_q & ~bus.redirect & ~halted_q;
    // rstn term keeps the strobe quiet while reset is held
    issue = rstn & bus.enable & ~bus.redirect & ~halted_q &
            ((occ <= 2'd1) | ((occ == 2'd2) & pop));
    new_entry = '{pc: inflight_pc_q, instr: bus.imem_rdata};

    if (issue) begin
      pc_d          = pc_q + 32'd4;
      inflight_pc_d = pc_q;
      inflight_d    = 1'b1;
    end

    // head is always q0; a pop shifts q1 forward
    if (pop) begin
      q0_d = q1_q;
    end
    if (push) begin
      if ((count_q - 2'(pop)) == 2'd0) begin
        q0_d = new_entry;
      end else begin
        q1_d = new_entry;
      end
`ifdef FETCH_HALT_EN
      if (bus.imem_rdata[31:26] == 6'h3f) begin
        halted_d = 1'b1;
      end
`endif
    end
    count_d = count_q + 2'(push) - 2'(pop);

    if (bus.redirect) begin
      count_d = 2'd0;
      pc_d    = bus.redirect_pc & ~32'h3;
`ifdef FETCH_HALT_EN
      halted_d = 1'b0;
`endif
    end

    valid_d = (count_d != 2'd0);
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      q0_q          <= '0;
      q1_q          <= '0;
      count_q       <= 2'd0;
      valid_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      q0_q          <= q0_d;
      q1_q          <= q1_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
    end
  end

`ifdef FETCH_HALT_EN
  // Halt flag, cleared only by redirect or reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
`endif

  // The issue rule must never let a response land on a full queue
  assert property (@(posedge clk) disable iff (!rstn) !(push && (count_q == 2'd2)));

  assign bus.imem_en   = issue;
  assign bus.imem_addr = pc_q[ADDR_W+1:2];
  assign bus.valid     = valid_q;
  assign bus.pc_out    = q0_q.pc;
  assign bus.command   = q0_q.instr;
  assign bus.halted    = halted_q;

endmodule
